// File: rtl/pagerank_iter_ctrl.sv
// Iteration sequencer for the pageRank update datapath: sweeps destinations,
// streams sources into the MAC, tracks the largest rank change and launches the final sort.
module pagerank_iter_ctrl #(
    parameter int N     = 64,
    parameter int WIDTH = 16,
    parameter int IDW   = 6,
    parameter int ITW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ITW-1:0]   max_iter,
    input  logic [WIDTH-1:0] threshold,
    output logic             mac_clr,
    output logic             mac_req,
    input  logic             mac_ready,
    output logic [IDW-1:0]   src_idx,
    output logic [IDW-1:0]   dst_idx,
    input  logic             acc_valid,
    input  logic [WIDTH-1:0] acc_val,
    input  logic [WIDTH-1:0] old_val,
    output logic             wr_en,
    output logic [IDW-1:0]   wr_idx,
    output logic [WIDTH-1:0] wr_data,
    output logic             buf_sel,
    output logic             sort_start,
    input  logic             sort_done,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [ITW-1:0]   iter_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ISSUE, S_WAIT, S_WRITE, S_ITEREND, S_SORT, S_DONE
    } state_t;

    localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

    state_t             state_q, state_d;
    logic [IDW-1:0]     src_q, src_d, dst_q, dst_d;
    logic [ITW-1:0]     cap_q, cap_d, iter_q, iter_d;
    logic [WIDTH-1:0]   thr_q, thr_d, max_delta_q, max_delta_d, wr_data_q, wr_data_d;
    logic               buf_sel_q, buf_sel_d, conv_q, conv_d;
    logic               mac_clr_q, mac_clr_d, mac_req_q, mac_req_d, wr_en_q, wr_en_d;
    logic               sort_start_q, sort_start_d, done_q, done_d, busy_q, busy_d;
    logic [WIDTH-1:0]   delta_s;
    logic [ITW-1:0]     next_iter_s;

    // Next-state, datapath-register and registered-output computation.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cap_d       = cap_q;
        iter_d      = iter_q;
        thr_d       = thr_q;
        max_delta_d = max_delta_q;
        wr_data_d   = wr_data_q;
        buf_sel_d   = buf_sel_q;
        conv_d      = conv_q;
        delta_s     = (acc_val >= old_val) ? (acc_val - old_val) : (old_val - acc_val);
        next_iter_s = iter_q + ITW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cap_d       = (max_iter == ITW'(0)) ? ITW'(1) : max_iter;
                    thr_d       = threshold;
                    iter_d      = ITW'(0);
                    conv_d      = 1'b0;
                    max_delta_d = WIDTH'(0);
                    dst_d       = IDW'(0);
                    state_d     = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                src_d   = IDW'(0);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mac_ready) begin
                    if (src_q == LAST_IDX) begin
                        state_d = S_WAIT;
                    end else begin
                        src_d = src_q + IDW'(1);
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (acc_valid) begin
                    if (delta_s > max_delta_q) begin
                        max_delta_d = delta_s;
                    end else begin
                        max_delta_d = max_delta_q;
                    end
                    wr_data_d = acc_val;
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                if (dst_q == LAST_IDX) begin
                    state_d = S_ITEREND;
                end else begin
                    dst_d   = dst_q + IDW'(1);
                    state_d = S_CLR;
                end
            end
            S_ITEREND: begin
                buf_sel_d = ~buf_sel_q;
                iter_d    = next_iter_s;
                // Convergence wins over the cap when both hold in the same iteration.
                if (max_delta_q <= thr_q) begin
                    conv_d  = 1'b1;
                    state_d = S_SORT;
                end else if (next_iter_s == cap_q) begin
                    state_d = S_SORT;
                end else begin
                    max_delta_d = WIDTH'(0);
                    dst_d       = IDW'(0);
                    state_d     = S_CLR;
                end
            end
            S_SORT: begin
                if (sort_done) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SORT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the registered state.
        mac_clr_d    = (state_d == S_CLR);
        mac_req_d    = (state_d == S_ISSUE);
        wr_en_d      = (state_d == S_WRITE);
        sort_start_d = (state_d == S_SORT) && (state_q != S_SORT);
        done_d       = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= IDW'(0);
            dst_q        <= IDW'(0);
            cap_q        <= ITW'(0);
            iter_q       <= ITW'(0);
            thr_q        <= WIDTH'(0);
            max_delta_q  <= WIDTH'(0);
            wr_data_q    <= WIDTH'(0);
            buf_sel_q    <= 1'b0;
            conv_q       <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_req_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            sort_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cap_q        <= cap_d;
            iter_q       <= iter_d;
            thr_q        <= thr_d;
            max_delta_q  <= max_delta_d;
            wr_data_q    <= wr_data_d;
            buf_sel_q    <= buf_sel_d;
            conv_q       <= conv_d;
            mac_clr_q    <= mac_clr_d;
            mac_req_q    <= mac_req_d;
            wr_en_q      <= wr_en_d;
            sort_start_q <= sort_start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign mac_clr    = mac_clr_q;
    assign mac_req    = mac_req_q;
    assign src_idx    = src_q;
    assign dst_idx    = dst_q;
    assign wr_en      = wr_en_q;
    assign wr_idx     = dst_q;
    assign wr_data    = wr_data_q;
    assign buf_sel    = buf_sel_q;
    assign sort_start = sort_start_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_pagerank_iter_ctrl.sv
// Self-checking bench: a datapath/sorter responder plus an iteration-level reference model.
module tb_pagerank_iter_ctrl;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;
    localparam int ITW   = 8;
    localparam int TABSZ = 64;

    logic             clk = 1'b0;
    logic             reset, start, mac_ready, acc_valid, sort_done;
    logic [ITW-1:0]   max_iter;
    logic [WIDTH-1:0] threshold, acc_val, old_val;
    logic             mac_clr, mac_req, wr_en, buf_sel, sort_start, busy, done, converged;
    logic [IDW-1:0]   src_idx, dst_idx, wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [ITW-1:0]   iter_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] acc_tab [TABSZ];
    logic [WIDTH-1:0] old_tab [TABSZ];
    logic exp_buf = 1'b0;

    pagerank_iter_ctrl #(.N(N), .WIDTH(WIDTH), .IDW(IDW), .ITW(ITW)) dut (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .threshold(threshold),
        .mac_clr(mac_clr), .mac_req(mac_req), .mac_ready(mac_ready), .src_idx(src_idx),
        .dst_idx(dst_idx), .acc_valid(acc_valid), .acc_val(acc_val), .old_val(old_val),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .buf_sel(buf_sel),
        .sort_start(sort_start), .sort_done(sort_done), .busy(busy), .done(done),
        .converged(converged), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Reference: iterate over whole sweeps, taking the largest |new-old| per sweep.
    function automatic void model(input logic [ITW-1:0] cap, input logic [WIDTH-1:0] thr,
                                  output int iters, output bit conv);
        int capv, md, a, o, df;
        capv  = (cap == 0) ? 1 : int'(cap);
        iters = 0;
        conv  = 1'b0;
        for (int it = 0; it < TABSZ / N; it++) begin
            md = 0;
            for (int d = 0; d < N; d++) begin
                a  = int'(acc_tab[it*N + d]);
                o  = int'(old_tab[it*N + d]);
                df = (a > o) ? a - o : o - a;
                if (df > md) md = df;
            end
            iters = it + 1;
            if (md <= int'(thr)) begin
                conv = 1'b1;
                break;
            end
            if (iters == capv) break;
        end
    endfunction

    task automatic fill_differ();
        for (int i = 0; i < TABSZ; i++) begin
            acc_tab[i] = WIDTH'($urandom);
            old_tab[i] = acc_tab[i] + WIDTH'($urandom_range(1, 255));
        end
    endtask

    task automatic run_scenario(input logic [ITW-1:0] cap, input logic [WIDTH-1:0] thr,
                                input bit rand_ready, input int abort_dst,
                                input bit midrun_start, input string name);
        int  cyc, issue_cnt, cd, r, w, sort_cnt, toggles, sd_wait, sd_cycle, exp_iters;
        bit  exp_conv, finished, sd_pend;
        logic prev_buf;
        model(cap, thr, exp_iters, exp_conv);
        cyc = 0; issue_cnt = 0; cd = 0; r = 0; w = 0; sort_cnt = 0; toggles = 0;
        sd_wait = 0; sd_cycle = -10; finished = 1'b0; sd_pend = 1'b0;
        prev_buf = buf_sel;
        max_iter = cap; threshold = thr; start = 1'b1;
        @(negedge clk);
        while (!finished && cyc < 5000) begin
            acc_valid = 1'b0;
            sort_done = 1'b0;
            start     = (midrun_start && cyc == 10) ? 1'b1 : 1'b0;
            if (midrun_start && cyc == 10) max_iter = ITW'(5);
            if (abort_dst >= 0 && mac_req && dst_idx == IDW'(abort_dst) && issue_cnt == 1) begin
                mac_ready = 1'b1;
                reset     = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                total_cnt++;
                if ({busy, mac_req, buf_sel, iter_count} !== {3'b000, ITW'(0)})
                    $display("FAIL %s abort: busy/mac_req/buf_sel/iter=%b/%b/%b/%0d want 0/0/0/0",
                             name, busy, mac_req, buf_sel, iter_count);
                else pass_cnt++;
                exp_buf   = 1'b0;
                acc_valid = 1'b1;
                acc_val   = 16'h1234;
                @(negedge clk);
                acc_valid = 1'b0;
                @(negedge clk);
                total_cnt++;
                if ({busy, wr_en} !== 2'b00)
                    $display("FAIL %s stray_acc: busy/wr_en=%b/%b want 0/0", name, busy, wr_en);
                else pass_cnt++;
                return;
            end
            mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_en) begin
                total_cnt++;
                if (wr_idx !== IDW'(w % N) || wr_data !== acc_tab[w])
                    $display("FAIL %s write%0d: idx=%0d data=%h want idx=%0d data=%h",
                             name, w, wr_idx, wr_data, w % N, acc_tab[w]);
                else pass_cnt++;
                w++;
                issue_cnt = 0;
            end
            if (mac_req && mac_ready) begin
                total_cnt++;
                if (src_idx !== IDW'(issue_cnt))
                    $display("FAIL %s issue: src_idx=%0d want %0d", name, src_idx, issue_cnt);
                else pass_cnt++;
                issue_cnt++;
                if (issue_cnt == N) cd = $urandom_range(1, 3);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    total_cnt++;
                    if (dst_idx !== IDW'(r % N))
                        $display("FAIL %s dst_hold: dst_idx=%0d want %0d", name, dst_idx, r % N);
                    else pass_cnt++;
                    acc_valid = 1'b1;
                    acc_val   = acc_tab[r];
                    old_val   = old_tab[r];
                    r++;
                end
            end else if (rand_ready && issue_cnt < N && $urandom_range(0, 7) == 0) begin
                acc_valid = 1'b1;
                acc_val   = WIDTH'($urandom);
                old_val   = WIDTH'($urandom);
            end
            if (buf_sel !== prev_buf) toggles++;
            prev_buf = buf_sel;
            if (sort_start) begin
                sort_cnt++;
                sd_wait = $urandom_range(0, 3);
                sd_pend = 1'b1;
            end else if (sd_pend && sd_wait > 0) begin
                sd_wait--;
            end
            if (sd_pend && sd_wait == 0 && !sort_start || sd_pend && sort_start && sd_wait == 0) begin
                sort_done = 1'b1;
                sd_pend   = 1'b0;
                sd_cycle  = cyc;
            end
            if (done) begin
                total_cnt++;
                if (cyc !== sd_cycle + 1)
                    $display("FAIL %s done_lat: done at %0d want %0d", name, cyc, sd_cycle + 1);
                else pass_cnt++;
                finished = 1'b1;
            end
            cyc++;
            if (!finished) @(negedge clk);
        end
        acc_valid = 1'b0;
        sort_done = 1'b0;
        start     = 1'b0;
        total_cnt++;
        if (!finished) begin
            $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
            return;
        end
        pass_cnt++;
        exp_buf = exp_buf ^ 1'(exp_iters % 2);
        total_cnt++;
        if (iter_count !== ITW'(exp_iters) || converged !== exp_conv)
            $display("FAIL %s result: iter=%0d conv=%b want iter=%0d conv=%b",
                     name, iter_count, converged, exp_iters, exp_conv);
        else pass_cnt++;
        total_cnt++;
        if (buf_sel !== exp_buf || toggles != exp_iters)
            $display("FAIL %s buf_sel: val=%b toggles=%0d want val=%b toggles=%0d",
                     name, buf_sel, toggles, exp_buf, exp_iters);
        else pass_cnt++;
        total_cnt++;
        if (w != exp_iters * N || r != exp_iters * N || sort_cnt != 1)
            $display("FAIL %s counts: writes=%0d resp=%0d sorts=%0d want %0d/%0d/1",
                     name, w, r, sort_cnt, exp_iters * N, exp_iters * N);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL %s idle: busy/done=%b/%b want 0/0", name, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({mac_clr, mac_req, src_idx, dst_idx, wr_en, wr_idx, wr_data, buf_sel,
             sort_start, busy, done, converged, iter_count} !== '0)
            $display("FAIL reset_outputs: some output nonzero busy=%b buf_sel=%b iter=%0d",
                     busy, buf_sel, iter_count);
        else pass_cnt++;
        reset = 1'b0;
        exp_buf = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_iter_cap();
        fill_differ();
        run_scenario(8'd3, 16'h0000, 1'b0, -1, 1'b0, "iter_cap");
    endtask

    task automatic test_converge();
        fill_differ();
        for (int i = N; i < 2 * N; i++) old_tab[i] = acc_tab[i];
        run_scenario(8'd3, 16'h0000, 1'b0, -1, 1'b0, "converge");
    endtask

    task automatic test_ready_stall();
        fill_differ();
        run_scenario(8'd3, 16'h0000, 1'b1, -1, 1'b0, "ready_stall");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < TABSZ; i++) begin
                acc_tab[i] = WIDTH'($urandom);
                old_tab[i] = acc_tab[i] + WIDTH'($urandom_range(0, 60));
            end
            run_scenario(ITW'($urandom_range(1, 6)), WIDTH'($urandom_range(0, 60)),
                         1'b1, -1, 1'b0, "random");
        end
    endtask

    task automatic test_delta_boundary();
        for (int i = 0; i < TABSZ; i++) begin
            acc_tab[i] = 16'h0000;
            old_tab[i] = 16'hFFFF;
        end
        run_scenario(8'd3, 16'hFFFF, 1'b0, -1, 1'b0, "delta_max_conv");
        run_scenario(8'd2, 16'hFFFE, 1'b0, -1, 1'b0, "delta_max_noconv");
    endtask

    task automatic test_reset_abort();
        fill_differ();
        run_scenario(8'd3, 16'h0000, 1'b0, 2, 1'b0, "reset_abort");
        fill_differ();
        run_scenario(8'd2, 16'h0000, 1'b1, -1, 1'b0, "after_abort");
    endtask

    task automatic test_midrun_start();
        fill_differ();
        run_scenario(8'd0, 16'h0000, 1'b0, -1, 1'b1, "cap_zero_midrun_start");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; max_iter = '0; threshold = '0; mac_ready = 1'b1;
        acc_valid = 1'b0; acc_val = '0; old_val = '0; sort_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_iter_cap();
        test_converge();
        test_ready_stall();
        test_random();
        test_delta_boundary();
        test_reset_abort();
        test_midrun_start();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
